// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl
//   Forwarding and load-use hazard controller for the integer pipeline.
//   Keeps a shadow scoreboard of the destination registers in flight across
//   DEPTH post-ID stages (stage 1 = EX, stage DEPTH = write-back). Every cycle
//   it checks each source operand of the instruction in ID against the
//   scoreboard. It then either registers per-source bypass selects for the
//   consumer's EX cycle, or raises a load-use stall and inserts a bubble.
//
// Ports
//   clk          clock
//   rst          asynchronous active-high reset
//   id_valid     ID holds a valid instruction
//   id_rs_addr   source addresses, src i at [i*RF_AWIDTH +: RF_AWIDTH]
//   id_rs_used   src i is actually read
//   id_rd_addr   destination address of the ID instruction
//   id_rd_wen    ID instruction writes the register file
//   id_is_load   ID instruction is a load
//   flush        kill the instruction in ID (branch redirect)
//   ext_stall    whole pipeline frozen (memory wait)
//   stall_id     hold PC/IF/ID this cycle (combinational)
//   fwd_sel_ex   per-source bypass select for the instruction now in EX;
//                0 = register file, k = output of stage k
//   stall_cnt    saturating count of hazard bubbles
module fwd_hazard_ctrl #(
    parameter int unsigned RF_AWIDTH  = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_STAGE = 3,
    parameter int unsigned CNT_W      = 32,
    localparam int unsigned SW        = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid,
    input  logic [NUM_SRC*RF_AWIDTH-1:0] id_rs_addr,
    input  logic [NUM_SRC-1:0]           id_rs_used,
    input  logic [RF_AWIDTH-1:0]         id_rd_addr,
    input  logic                         id_rd_wen,
    input  logic                         id_is_load,
    input  logic                         flush,
    input  logic                         ext_stall,
    output logic                         stall_id,
    output logic [NUM_SRC*SW-1:0]        fwd_sel_ex,
    output logic [CNT_W-1:0]             stall_cnt
);

    // Scoreboard, index k = pipeline stage (1 = EX .. DEPTH = WB)
    logic                 v_q  [1:DEPTH];
    logic [RF_AWIDTH-1:0] rd_q [1:DEPTH];
    logic                 ld_q [1:DEPTH];

    logic [NUM_SRC*SW-1:0] fwd_sel_q, fwd_sel_d;
    logic [NUM_SRC*SW-1:0] sel_calc;
    logic [NUM_SRC-1:0]    haz_src;
    logic [RF_AWIDTH-1:0]  rs_cur;
    logic                  hazard;
    logic                  bubble;
    logic                  s1_v_d;
    logic [RF_AWIDTH-1:0]  s1_rd_d;
    logic                  s1_ld_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // Per-source match. Stages are scanned oldest to youngest, so the
    // youngest (lowest k) match is the one left standing. The producer moves
    // on together with the consumer, so a match at stage k is read from
    // stage k+1 next cycle. A match at stage DEPTH commits this cycle and is
    // served by register-file write-through (select 0).
    always_comb begin
        sel_calc = '0;
        haz_src  = '0;
        rs_cur   = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            rs_cur = id_rs_addr[i*RF_AWIDTH +: RF_AWIDTH];
            if (id_valid && id_rs_used[i] && (rs_cur != '0)) begin
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    if (v_q[DEPTH-j] && (rd_q[DEPTH-j] == rs_cur)) begin
                        sel_calc[i*SW +: SW] = '0;
                        haz_src[i]           = 1'b0;
                        if ((DEPTH - j) < DEPTH) begin
                            if (ld_q[DEPTH-j] && ((DEPTH - j + 1) < LOAD_STAGE)) begin
                                haz_src[i] = 1'b1;
                            end else begin
                                sel_calc[i*SW +: SW] = SW'(DEPTH - j + 1);
                            end
                        end
                    end
                end
            end
        end
    end

    assign hazard   = |haz_src;
    assign stall_id = hazard && !flush && !ext_stall && !rst;

    // A flush takes precedence over a hazard: both insert a bubble, but only
    // a hazard bubble is counted.
    always_comb begin
        bubble    = flush || hazard;
        s1_v_d    = 1'b0;
        s1_rd_d   = '0;
        s1_ld_d   = 1'b0;
        fwd_sel_d = '0;
        cnt_d     = cnt_q;
        if (!bubble) begin
            s1_v_d    = id_valid && id_rd_wen && (id_rd_addr != '0);
            s1_rd_d   = id_rd_addr;
            s1_ld_d   = id_is_load;
            fwd_sel_d = sel_calc;
        end
        if (!flush && hazard && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                v_q[k]  <= 1'b0;
                rd_q[k] <= '0;
                ld_q[k] <= 1'b0;
            end
            fwd_sel_q <= '0;
            cnt_q     <= '0;
        end else if (!ext_stall) begin
            for (int unsigned k = 2; k <= DEPTH; k++) begin
                v_q[k]  <= v_q[k-1];
                rd_q[k] <= rd_q[k-1];
                ld_q[k] <= ld_q[k-1];
            end
            v_q[1]    <= s1_v_d;
            rd_q[1]   <= s1_rd_d;
            ld_q[1]   <= s1_ld_d;
            fwd_sel_q <= fwd_sel_d;
            cnt_q     <= cnt_d;
        end
    end

    assign fwd_sel_ex = fwd_sel_q;
    assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
module tb_fwd_hazard_ctrl;

    localparam int D  = 3;
    localparam int LS = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        id_valid;
    logic [9:0]  id_rs_addr;
    logic [1:0]  id_rs_used;
    logic [4:0]  id_rd_addr;
    logic        id_rd_wen, id_is_load, flush, ext_stall;
    logic [14:0] c_rs_addr;
    logic [2:0]  c_rs_used;

    logic        a_stall, b_stall, c_stall;
    logic [3:0]  a_fwd, b_fwd;
    logic [8:0]  c_fwd;
    logic [31:0] a_cnt, c_cnt;
    logic [1:0]  b_cnt;

    fwd_hazard_ctrl u_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
        .id_rs_used(id_rs_used), .id_rd_addr(id_rd_addr), .id_rd_wen(id_rd_wen),
        .id_is_load(id_is_load), .flush(flush), .ext_stall(ext_stall),
        .stall_id(a_stall), .fwd_sel_ex(a_fwd), .stall_cnt(a_cnt)
    );

    fwd_hazard_ctrl #(.CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
        .id_rs_used(id_rs_used), .id_rd_addr(id_rd_addr), .id_rd_wen(id_rd_wen),
        .id_is_load(id_is_load), .flush(flush), .ext_stall(ext_stall),
        .stall_id(b_stall), .fwd_sel_ex(b_fwd), .stall_cnt(b_cnt)
    );

    fwd_hazard_ctrl #(.NUM_SRC(3), .DEPTH(4), .LOAD_STAGE(4)) u_c (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(c_rs_addr),
        .id_rs_used(c_rs_used), .id_rd_addr(id_rd_addr), .id_rd_wen(id_rd_wen),
        .id_is_load(id_is_load), .flush(flush), .ext_stall(ext_stall),
        .stall_id(c_stall), .fwd_sel_ex(c_fwd), .stall_cnt(c_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model for u_a: history of the last D issue slots, newest
    // first; a producer found at age a is read from age a+1 next cycle.
    typedef struct {bit v; int rd; bit ld;} ent_t;
    ent_t        hist[$];
    int          mc_sel[2];
    bit          m_haz;
    logic [3:0]  m_fwd;
    logic [31:0] m_cnt;

    function automatic void model_reset();
        ent_t e;
        e.v = 0; e.rd = 0; e.ld = 0;
        hist.delete();
        for (int i = 0; i < D; i++) hist.push_back(e);
        m_fwd = '0;
        m_cnt = '0;
    endfunction

    function automatic void model_comb();
        int rs;
        m_haz = 0;
        for (int i = 0; i < 2; i++) begin
            mc_sel[i] = 0;
            rs = int'(id_rs_addr[i*5 +: 5]);
            if (id_valid && id_rs_used[i] && rs != 0) begin
                for (int j = 0; j < D; j++) begin
                    if (hist[j].v && hist[j].rd == rs) begin
                        if (j + 1 == D) mc_sel[i] = 0;
                        else if (hist[j].ld && (j + 2) < LS) m_haz = 1;
                        else mc_sel[i] = j + 2;
                        break;
                    end
                end
            end
        end
    endfunction

    function automatic void model_edge();
        ent_t e;
        bit   bub;
        if (ext_stall) return;
        bub  = flush || m_haz;
        e.v  = !bub && id_valid && id_rd_wen && (id_rd_addr != 0);
        e.rd = int'(id_rd_addr);
        e.ld = id_is_load;
        hist.push_front(e);
        void'(hist.pop_back());
        m_fwd = bub ? 4'd0 : 4'(mc_sel[1] * 4 + mc_sel[0]);
        if (!flush && m_haz && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    endfunction

    logic pre_a, pre_b, pre_c;

    // Inputs are driven just after a rising edge; stall_id is sampled
    // mid-cycle, registered outputs #1 after the following edge.
    task automatic cycle();
        #2;
        model_comb();
        pre_a = a_stall; pre_b = b_stall; pre_c = c_stall;
        chk("ref_stall_id", a_stall, m_haz && !flush && !ext_stall);
        @(posedge clk);
        model_edge();
        #1;
        chk("ref_fwd_sel", a_fwd, m_fwd);
        chk("ref_stall_cnt", a_cnt, m_cnt);
    endtask

    task automatic drive(input bit v, input int rs0, input int rs1, input int u,
                         input int rd, input bit wen, input bit ld, input bit fl, input bit ex);
        id_valid   = v;
        id_rs_addr = {5'(rs1), 5'(rs0)};
        id_rs_used = 2'(u);
        id_rd_addr = 5'(rd);
        id_rd_wen  = wen;
        id_is_load = ld;
        flush      = fl;
        ext_stall  = ex;
    endtask

    typedef struct {
        bit v; int rs0; int rs1; int u; int rd; bit wen; bit ld; bit fl; bit ex;
        bit st; int s0; int s1; int cnt;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input bit v, input int rs0, input int rs1, input int u,
                                input int rd, input bit wen, input bit ld, input bit fl,
                                input bit ex, input bit st, input int s0, input int s1,
                                input int cnt);
        vec_t r;
        r.v = v; r.rs0 = rs0; r.rs1 = rs1; r.u = u; r.rd = rd; r.wen = wen; r.ld = ld;
        r.fl = fl; r.ex = ex; r.st = st; r.s0 = s0; r.s1 = s1; r.cnt = cnt;
        tbl.push_back(r);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        c_rs_addr = '0;
        c_rs_used = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        chk("rst_stall", a_stall, 0);
        chk("rst_fwd", a_fwd, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_cnt_b", b_cnt, 0);
        chk("rst_fwd_c", c_fwd, 0);
        chk("rst_cnt_c", c_cnt, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        //   v rs0 rs1 u rd wen ld fl ex | st s0 s1 cnt
        add(1, 0, 0, 0, 5, 1, 0, 0, 0,   0, 0, 0, 0);   // add x5
        add(1, 5, 5, 3, 6, 1, 0, 0, 0,   0, 2, 2, 0);   // add x6,x5,x5
        add(1, 0, 0, 0, 7, 1, 1, 0, 0,   0, 0, 0, 0);   // lw x7
        add(1, 7, 0, 3, 8, 1, 0, 0, 0,   1, 0, 0, 1);   // add x8,x7,x0 stalls
        add(1, 7, 0, 3, 8, 1, 0, 0, 0,   0, 3, 0, 1);   // retry, sel WB
        add(1, 0, 0, 0, 9, 1, 0, 0, 0,   0, 0, 0, 1);   // add x9
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);   // nop
        add(1, 0, 0, 0, 9, 1, 0, 0, 0,   0, 0, 0, 1);   // add x9
        add(1, 9, 9, 3, 1, 1, 0, 0, 0,   0, 2, 2, 1);   // sub: youngest wins
        add(1, 0, 0, 0, 9, 1, 0, 0, 0,   0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
        add(1, 0, 0, 0, 9, 1, 0, 0, 0,   0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
        add(1, 9, 9, 3, 1, 1, 0, 0, 0,   0, 3, 3, 1);   // one extra nop
        add(1, 0, 0, 0, 9, 1, 0, 0, 0,   0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
        add(1, 0, 0, 0, 9, 1, 0, 0, 0,   0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
        add(1, 9, 9, 3, 1, 1, 0, 0, 0,   0, 0, 0, 1);   // two extra nops
        add(1, 0, 0, 0, 3, 1, 1, 0, 0,   0, 0, 0, 1);   // lw x3
        add(1, 3, 0, 3, 4, 1, 0, 1, 0,   0, 0, 0, 1);   // consumer flushed
        add(1, 4, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1);   // x4 must not match
        add(1, 0, 0, 0,12, 1, 0, 0, 0,   0, 0, 0, 1);   // add x12
        add(1,12, 0, 1,10, 1, 1, 0, 0,   0, 2, 0, 1);   // lw x10,(x12)
        add(1, 0,10, 3,11, 1, 0, 0, 1,   0, 2, 0, 1);   // frozen
        add(1, 0,10, 3,11, 1, 0, 1, 1,   0, 2, 0, 1);   // frozen, flush ignored
        add(1, 0,10, 3,11, 1, 0, 0, 1,   0, 2, 0, 1);
        add(1, 0,10, 3,11, 1, 0, 0, 1,   0, 2, 0, 1);
        add(1, 0,10, 3,11, 1, 0, 0, 0,   1, 0, 0, 2);   // released: one bubble
        add(1, 0,10, 3,11, 1, 0, 0, 0,   0, 0, 3, 2);

        foreach (tbl[n]) begin
            drive(tbl[n].v, tbl[n].rs0, tbl[n].rs1, tbl[n].u, tbl[n].rd,
                  tbl[n].wen, tbl[n].ld, tbl[n].fl, tbl[n].ex);
            cycle();
            chk($sformatf("tbl%0d_stall", n), pre_a, tbl[n].st);
            chk($sformatf("tbl%0d_sel0", n), a_fwd[1:0], tbl[n].s0);
            chk($sformatf("tbl%0d_sel1", n), a_fwd[3:2], tbl[n].s1);
            chk($sformatf("tbl%0d_cnt", n), a_cnt, tbl[n].cnt);
        end

        // Asynchronous reset while a load-use hazard is pending
        drive(1, 11, 0, 1, 7, 1, 1, 0, 0);
        cycle();
        chk("prerst_fwd", a_fwd, 4'b0010);
        drive(1, 7, 0, 1, 8, 1, 0, 0, 0);
        #2;
        chk("prerst_stall", a_stall, 1);
        rst = 1'b1;
        model_reset();
        #1;
        chk("midrst_stall", a_stall, 0);
        chk("midrst_fwd", a_fwd, 0);
        chk("midrst_cnt", a_cnt, 0);
        chk("midrst_cnt_b", b_cnt, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Saturation of the 2-bit counter over five load-use pairs
        for (int n = 1; n <= 5; n++) begin
            drive(1, 0, 0, 0, 7, 1, 1, 0, 0);
            cycle();
            drive(1, 7, 0, 1, 8, 1, 0, 0, 0);
            cycle();
            chk("sat_stall_b", pre_b, 1);
            cycle();
            chk("sat_nostall_b", pre_b, 0);
            chk("sat_cnt_b", b_cnt, (n > 3) ? 3 : n);
            chk("sat_cnt_a", a_cnt, n);
        end

        // Three sources, DEPTH 4, load data from stage 4: two bubbles
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) cycle();
        drive(1, 0, 0, 0, 7, 1, 1, 0, 0);
        cycle();
        chk("c_ld_stall", pre_c, 0);
        c_rs_addr = {5'd7, 5'd7, 5'd0};
        c_rs_used = 3'b111;
        drive(1, 0, 0, 0, 8, 1, 0, 0, 0);
        cycle();
        chk("c_bub1_stall", pre_c, 1);
        chk("c_bub1_fwd", c_fwd, 0);
        cycle();
        chk("c_bub2_stall", pre_c, 1);
        chk("c_bub2_fwd", c_fwd, 0);
        cycle();
        chk("c_go_stall", pre_c, 0);
        chk("c_go_fwd", c_fwd, 9'b100_100_000);
        chk("c_go_cnt", c_cnt, 2);
        c_rs_addr = '0;
        c_rs_used = '0;

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(9) != 0, $urandom_range(3), $urandom_range(3),
                  $urandom_range(3), $urandom_range(3), $urandom_range(1) != 0,
                  $urandom_range(2) == 0, $urandom_range(9) == 0, $urandom_range(9) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
Parametrised forwarding and hazard controller for the integer pipeline. It keeps a shadow scoreboard of in-flight destination registers across DEPTH post-ID stages (EX=1, DM=2, WB=3 by default). It evaluates every source operand of the instruction in ID, and for each cycle it does one of two things:
- registers per-source bypass selects for use in EX on the next cycle, or
- raises a load-use stall and inserts a bubble.

It replaces fixed two-source DM/WB priority logic with N sources, configurable depth and configurable load-data latency.

Parameters:
RF_AWIDTH, 5, register address width
NUM_SRC, 2, number of source operands checked per instruction
DEPTH, 3, tracked post-ID stages (min 2); stage DEPTH is write-back
LOAD_STAGE, 3, first stage whose output carries load data (2..DEPTH)
CNT_W, 32, stall-counter width
SW (local), $clog2(DEPTH+1), select width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
id_valid  in  1  ID holds a valid instruction
id_rs_addr  in  NUM_SRC*RF_AWIDTH  source addresses, src i at [i*RF_AWIDTH +: RF_AWIDTH]
id_rs_used  in  NUM_SRC  src i is actually read
id_rd_addr  in  RF_AWIDTH  destination address
id_rd_wen  in  1  instruction writes the register file
id_is_load  in  1  instruction is a load
flush  in  1  kill instruction in ID (branch redirect)
ext_stall  in  1  whole pipeline frozen (memory wait)
stall_id  out  1  hold PC/IF/ID this cycle (combinational)
fwd_sel_ex  out  NUM_SRC*SW  per-source bypass select for the instruction now in EX; 0 = register file, k = stage k output (2..DEPTH)
stall_cnt  out  CNT_W  saturating count of hazard bubbles

Behaviour:
- Scoreboard entry per stage k (1..DEPTH) holds: v (valid and writes rd≠x0), rd, ld.
- Reset (async): all v=0, rd=0, ld=0, fwd_sel_ex=0, stall_cnt=0. stall_id=0 while in reset.
- Match for source i: id_valid && id_rs_used[i] && rs_i≠0 && stage k v && rd_k==rs_i.
- Youngest match wins: the lowest k has priority. Per-source matches are independent.
- Target select for a youngest match at current stage k is t=k+1 (the producer advances with the consumer):
  - t≤DEPTH and (!ld_k or t≥LOAD_STAGE): select t.
  - t≤DEPTH and ld_k and t<LOAD_STAGE: hazard.
  - k==DEPTH: the producer commits this cycle, so select 0. The register file provides write-through.
- No match gives select 0.
- hazard = OR over sources. stall_id = hazard && !flush && !ext_stall.
- Each rising edge, in priority order:
  1. ext_stall=1: all state, including fwd_sel_ex and stall_cnt, holds. flush is ignored; the requester holds flush until accepted.
  2. flush=1: shift stages (k+1 <= k); stage1 <= bubble (v=0); fwd_sel_ex <= 0.
  3. hazard=1: shift; stage1 <= bubble; fwd_sel_ex <= 0; stall_cnt += 1, saturating at all-ones.
  4. Otherwise: shift; stage1 <= {id_valid && id_rd_wen && id_rd_addr≠0, id_rd_addr, id_is_load}; fwd_sel_ex <= computed selects.
- The stage-DEPTH entry is discarded on every shift.
- Latency:
  - selects are registered, valid in the cycle the consumer occupies EX;
  - stall_id is same-cycle.
- Defaults (DEPTH=3, LOAD_STAGE=3) produce a one-bubble load-use penalty, ALU→ALU forwarding from DM (sel 2), and forwarding from WB (sel 3).
- A source reading x0 or with used=0 never stalls and always selects 0.
- Two sources matching different producers get independent selects. Both matching the same producer get identical selects.

Test Plan:
- Issue add x5 (load=0), then add x6,x5,x5 next cycle → no stall; fwd_sel_ex = {2,2} in the consumer's EX cycle.
- lw x7, then add x8,x7,x0 → stall_id=1 for exactly 1 cycle, stall_cnt=1; consumer's EX cycle shows src0 sel=3, src1 sel=0.
- add x9; nop; add x9; then sub x1,x9,x9 → youngest wins, sel=2 (not 3). Repeat with one extra nop → sel=3; two extra nops → sel=0.
- lw x3 followed by a consumer, with flush=1 asserted during the stall cycle → stall_id=0, stage1 bubble, stall_cnt unchanged, fwd_sel_ex=0.
- ext_stall held 4 cycles mid load-use → scoreboard, fwd_sel_ex and stall_cnt frozen; after release exactly one bubble is inserted. Assert rst mid-sequence → all outputs 0 immediately.
- CNT_W=2, 5 load-use pairs → stall_cnt saturates at 3. Also run NUM_SRC=3, DEPTH=4, LOAD_STAGE=4 with a load followed by a consumer → 2 bubbles, then sel=4.
